// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank: channel indices and default geometry.
// Datapath event channels map onto these indices by convention.
package cpu_perf_pkg;
  localparam int CH_INSTR   = 0;
  localparam int CH_STALL   = 1;
  localparam int CH_BRANCH  = 2;
  localparam int CH_MEM     = 3;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SEL_W  = 2;
endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and read-port bundle between datapath/debug logic (master) and the counter bank (slave).
// rd_valid is a one-cycle pulse per request; there is no backpressure on the read port.
interface perf_counter_bank_if
  import cpu_perf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
);
  logic              enable;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] clear;
  logic              snapshot;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output enable, inc, clear, snapshot, rd_en, rd_sel,
    input  rd_data, rd_valid, overflow
  );

  modport slave (
    input  enable, inc, clear, snapshot, rd_en, rd_sel,
    output rd_data, rd_valid, overflow
  );
endinterface

// File: rtl/perf_counter_bank_channel.sv
// One event counter with sticky overflow and a shadow register; updates every cycle, no stall path.
// Priority: clear, then increment, then hold; the shadow always captures the pre-edge count.
module perf_counter_channel
  import cpu_perf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_inc,
  input  logic             cnt_clr,
  input  logic             snap,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    shadow_d = snap ? count_q : shadow_q;
    if (cnt_clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (cnt_inc) begin
      if (&count_q) begin
        // At all-ones: either pin or roll over, and latch the event either way
        count_d = (SATURATE != 0) ? count_q : '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign shadow = shadow_q;
  assign ovf    = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// NUM_CH event counters with atomic snapshot and a 1-cycle registered shadow read port.
// rd_valid pulses the cycle after rd_en; reads are never stalled and out-of-range selects return 0.
module perf_counter_bank
  import cpu_perf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SATURATE = 0,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic                clk,
  input  logic                reset,
  perf_counter_bank_if.slave  bus
);
  logic [WIDTH-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .cnt_inc (bus.enable & bus.inc[i]),
      .cnt_clr (bus.clear[i]),
      .snap    (bus.snapshot),
      .shadow  (shadow[i]),
      .ovf     (ovf[i])
    );
  end

  // Read mux sees pre-edge shadows, so a same-edge snapshot is only visible on the next read
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (bus.rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.rd_sel == SEL_W'(i)) rd_data_d = shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Drives a 3-channel wrapping bank and a 4-channel saturating bank (both 4-bit) with shared stimulus;
// reads are scoreboarded against an arithmetic reference model and popped by an independent monitor.
module tb_perf_counter_bank;
  import cpu_perf_pkg::*;

  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] inc = '0;
  logic [3:0] clear = '0;
  logic       snapshot = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = wrap bank (3 ch), 1 = saturate bank (4 ch)
  int cnt_m [2][4];
  int shd_m [2][4];
  int ovf_m [2][4];
  int last_m [2];
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  perf_counter_bank_if #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) ifw ();
  perf_counter_bank_if #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) ifs ();

  assign ifw.enable   = enable;
  assign ifw.inc      = inc[2:0];
  assign ifw.clear    = clear[2:0];
  assign ifw.snapshot = snapshot;
  assign ifw.rd_en    = rd_en;
  assign ifw.rd_sel   = rd_sel;
  assign ifs.enable   = enable;
  assign ifs.inc      = inc;
  assign ifs.clear    = clear;
  assign ifs.snapshot = snapshot;
  assign ifs.rd_en    = rd_en;
  assign ifs.rd_sel   = rd_sel;

  perf_counter_bank #(.WIDTH(4), .NUM_CH(3), .SATURATE(0), .SEL_W(2)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (ifw)
  );

  perf_counter_bank #(.WIDTH(4), .NUM_CH(4), .SATURATE(1), .SEL_W(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_ovf(input int m);
    int v = 0;
    for (int i = 0; i < 4; i++) v += ovf_m[m][i] << i;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      last_m[m] = 0;
      for (int i = 0; i < 4; i++) begin
        cnt_m[m][i] = 0;
        shd_m[m][i] = 0;
        ovf_m[m][i] = 0;
      end
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge of the reference: read old shadow, snapshot old counts, then count
  task automatic model_edge();
    int nch;
    int n;
    int rv;
    for (int m = 0; m < 2; m++) begin
      nch = (m == 0) ? 3 : 4;
      if (rd_en) begin
        rv = (int'(rd_sel) < nch) ? shd_m[m][rd_sel] : 0;
        last_m[m] = rv;
        if (m == 0) q0.push_back(rv);
        else        q1.push_back(rv);
      end
      if (snapshot) for (int i = 0; i < nch; i++) shd_m[m][i] = cnt_m[m][i];
      for (int i = 0; i < nch; i++) begin
        if (clear[i]) begin
          cnt_m[m][i] = 0;
          ovf_m[m][i] = 0;
        end else if (enable && inc[i]) begin
          n = cnt_m[m][i] + 1;
          if (n > MAXV) begin
            ovf_m[m][i] = 1;
            n = (m == 1) ? MAXV : n - (MAXV + 1);
          end
          cnt_m[m][i] = n;
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic [3:0] in_v, input logic [3:0] cl_v,
                      input logic sn, input logic re, input logic [1:0] sel);
    @(negedge clk);
    enable   = en;
    inc      = in_v;
    clear    = cl_v;
    snapshot = sn;
    rd_en    = re;
    rd_sel   = sel;
    @(posedge clk);
    if (reset) model_edge();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic mon(input int m, input logic vld, input logic [3:0] dat, input logic [3:0] ovf);
    int sz;
    int ev;
    sz = (m == 0) ? q0.size() : q1.size();
    if (vld) begin
      if (sz == 0) begin
        chk($sformatf("rd_valid_unexpected[%0d]", m), 1, 0);
      end else begin
        if (m == 0) ev = q0.pop_front();
        else        ev = q1.pop_front();
        chk($sformatf("rd_data[%0d]", m), int'(dat), ev);
      end
    end else begin
      if (sz != 0) begin
        chk($sformatf("rd_valid_missing[%0d]", m), 0, 1);
        if (m == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      chk($sformatf("rd_data_hold[%0d]", m), int'(dat), last_m[m]);
    end
    chk($sformatf("overflow[%0d]", m), int'(ovf), exp_ovf(m));
  endtask

  always @(negedge clk) begin
    mon(0, ifw.rd_valid, ifw.rd_data, {1'b0, ifw.overflow});
    mon(1, ifs.rd_valid, ifs.rd_data, ifs.overflow);
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_valid_w"}, int'(ifw.rd_valid), 0);
    chk({tag, "_rd_data_w"},  int'(ifw.rd_data), 0);
    chk({tag, "_overflow_w"}, int'(ifw.overflow), 0);
    chk({tag, "_rd_valid_s"}, int'(ifs.rd_valid), 0);
    chk({tag, "_rd_data_s"},  int'(ifs.rd_data), 0);
    chk({tag, "_overflow_s"}, int'(ifs.overflow), 0);
  endtask

  task automatic snap_read(input logic [1:0] sel);
    step(1'b1, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 4'b0, 4'b0, 1'b0, 1'b1, sel);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 chk_zero_outputs("reset");
    idle(2);
    #1 reset = 1'b1;

    // Basic count on the instruction channel
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0001 << CH_INSTR, 4'b0, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_INSTR));

    // Clear beats inc; enable low freezes counting
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0010, 4'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_STALL));

    // Wrap past all-ones on channel 2, then clear it
    for (int k = 0; k < 17; k++) step(1'b1, 4'b0100, 4'b0, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_BRANCH));
    step(1'b1, 4'b0, 4'b0100, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_BRANCH));

    // Saturate on channel 3 (out of range on the 3-channel bank), then exactly 15
    for (int k = 0; k < 20; k++) step(1'b1, 4'b1000, 4'b0, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_MEM));
    step(1'b1, 4'b0, 4'b1000, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 15; k++) step(1'b1, 4'b1000, 4'b0, 1'b0, 1'b0, 2'd0);
    snap_read(2'(CH_MEM));

    // Atomic read-and-clear, plus snapshot with same-edge read returning the old shadow
    step(1'b1, 4'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 9; k++) step(1'b1, 4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0);
    step(1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 2'd0);
    snap_read(2'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [3:0] cl;
      for (int b = 0; b < 4; b++) cl[b] = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 4) != 0, 4'($urandom), cl, $urandom_range(0, 3) == 0,
           1'($urandom), 2'($urandom));
    end

    // Async reset mid-read with overflow flags set
    for (int k = 0; k < 17; k++) step(1'b1, 4'b1111, 4'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 4'b1111, 4'b0, 1'b0, 1'b1, 2'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_zero_outputs("async_reset");
    idle(2);
    #1 reset = 1'b1;
    for (int s = 0; s < 4; s++) snap_read(2'(s));
    idle(3);

    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised successor to the single instruction-count register.
- Holds NUM_CH independent event counters, e.g. instructions retired, stalls, branches and memory ops.
- Adds global enable, per-channel clear, wrap or saturate mode, sticky overflow flags, an atomic snapshot into shadow registers, and a registered read port.
- Sits beside the control unit; event strobes come from the datapath, and the debug/monitor logic reads results.

Parameters:
- WIDTH, 16, bits per counter (minimum 2).
- NUM_CH, 4, number of counter channels (minimum 1).
- SATURATE, 0, 0 = counters wrap at 2^WIDTH; 1 = counters hold at all-ones.
- SEL_W, 2, width of rd_sel; must satisfy 2^SEL_W >= NUM_CH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global count enable; when 0, inc is ignored.
- inc  input  NUM_CH  per-channel increment strobe; +1 per cycle when high.
- clear  input  NUM_CH  per-channel synchronous clear of count and overflow flag.
- snapshot  input  1  copies all live counts into shadow registers.
- rd_en  input  1  read request.
- rd_sel  input  SEL_W  shadow channel to read.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  high the cycle rd_data is valid.
- overflow  output  NUM_CH  sticky per-channel overflow/saturation flag.

Behaviour:
- Reset (reset=0, asynchronous): all counts, shadows, overflow, rd_data and rd_valid go to 0 immediately, regardless of clk. Counting resumes on the first posedge after reset returns high.
- Per-channel update priority, evaluated each posedge:
  1. clear[i] → count 0, overflow[i] 0. Clear beats inc: clear and inc in the same cycle gives 0, not 1.
  2. enable && inc[i] → increment.
  3. Otherwise → hold.
- Wrap mode (SATURATE=0): all-ones + 1 → 0; overflow[i] is set on that same edge.
- Saturate mode (SATURATE=1): an increment at all-ones holds the count at all-ones and sets overflow[i]. Reaching all-ones from all-ones−1 does not set the flag.
- overflow[i] stays set until clear[i] or reset. Further overflows do not toggle it.
- Snapshot: on a posedge with snapshot=1, shadow[i] <= the pre-edge live count, for all channels together.
  - Any same-edge clear or inc affects only the live counter.
  - snapshot together with clear[i] is therefore an atomic read-and-clear.
- Read port, latency 1:
  - On a posedge with rd_en=1: rd_data <= shadow[rd_sel] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - rd_sel >= NUM_CH returns rd_data = 0 with rd_valid = 1.
  - snapshot and rd_en on the same edge return the old shadow; the new value is visible from the next read.
- enable=0 freezes counting only. Clear, snapshot and reads still operate.
- Reset asserted mid-operation (mid-read or mid-snapshot) discards everything; there is no partial state.
- There is no FSM. The block is NUM_CH counters plus shadows plus one read pipeline register.

Decomposition:
- Shared package cpu_perf_pkg holds:
  - the channel index constants: CH_INSTR=0, CH_STALL=1, CH_BRANCH=2, CH_MEM=3;
  - default WIDTH and NUM_CH.
- One sub-module, perf_counter_channel, holds one counter, its overflow flag, its shadow register, and the clear/inc/saturate logic, with WIDTH and SATURATE as parameters.
- The top instantiates NUM_CH copies of perf_counter_channel in a generate loop and adds the read mux/register.

Test Plan:
- Reset and basic count: hold reset=0 for 2 cycles, then release; enable=1, inc=4'b0001 for 5 cycles; snapshot; rd_en with rd_sel=0 → next cycle rd_valid=1, rd_data=5, overflow=0.
- Clear priority and enable gating: inc[1]=1 for 3 cycles, then clear[1] and inc[1] together for 1 cycle, then enable=0 with inc[1]=1 for 4 cycles; snapshot and read channel 1 → rd_data=0.
- Wrap (WIDTH=4, SATURATE=0): 17 increments on channel 2 → count 1, overflow[2]=1; clear[2] → count 0, overflow[2]=0.
- Saturate (WIDTH=4, SATURATE=1): 20 increments on channel 3 → count 15, overflow[3]=1. A separate run of exactly 15 increments → count 15, overflow[3]=0.
- Atomic read-and-clear: count channel 0 to 9; on one edge assert snapshot, clear[0] and inc[0]; read → 9, live count 0; snapshot again and read → 0.
- Async reset mid-read: assert rd_en and drop reset between clock edges → rd_valid, rd_data, counts and overflow are 0 before the next posedge. Also, rd_sel=3 with NUM_CH=3 → rd_data=0, rd_valid=1.
